// File: rtl/motor_queue_pkg.sv
// motor_queue_pkg: shared FSM state, queue entry layout and data width for motor_queue_cont.
// Queue entries are sized for MAX_MOTORS axes; motor_queue_cont needs MOTORS <= MAX_MOTORS.
package motor_queue_pkg;
  localparam int W = 32;
  localparam int MAX_MOTORS = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, SYNC} state_t;
  typedef struct packed {
    logic [MAX_MOTORS-1:0][W-1:0] n;
    logic [MAX_MOTORS-1:0][W-1:0] t;
    logic [W-1:0]                 task_id;
  } seg_t;
endpackage

// File: rtl/axis_step_gen.sv
// axis_step_gen: one axis of step timing. It holds the remaining step count, the period in
// ticks, the phase counter and the direction latched at load.
module axis_step_gen
  import motor_queue_pkg::*;
(
  input  logic         clk,
  input  logic         aclr_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         tick,
  input  logic [W-1:0] n,
  input  logic [W-1:0] t,
  output logic         step,
  output logic         dir,
  output logic         run
);
  logic [W-1:0] cnt, per, phase;
  logic wrap;
  assign run = cnt != '0;
  assign wrap = tick && run && phase == per - 1'b1;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      cnt   <= '0;
      per   <= W'(1);
      phase <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= '0;
      step  <= 1'b0;
    end else if (ld) begin
      cnt   <= n[W-1] ? -n : n;
      dir   <= n[W-1];
      per   <= t == '0 ? W'(1) : t;
      phase <= '0;
      step  <= 1'b0;
    end else begin
      step <= wrap;
      if (tick && run) begin
        phase <= wrap ? '0 : phase + 1'b1;
        cnt   <= wrap ? cnt - 1'b1 : cnt;
      end
    end
endmodule

// File: rtl/motor_queue_cont.sv
// motor_queue_cont: queued multi-axis step generator with prescaled timing and segment sync.
// Define MOTOR_QUEUE_STAT_EN to enable the wrapping seg_count statistics counter.
module motor_queue_cont
  import motor_queue_pkg::*;
#(
  parameter int MOTORS = 8,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         sclr,
  input  logic                         abort,
  input  logic                         permit,
  input  logic [15:0]                  T_scale,
  input  logic                         wr,
  input  logic [MOTORS-1:0][W-1:0]     N,
  input  logic [MOTORS-1:0][W-1:0]     T,
  input  logic [W-1:0]                 task_id,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       level,
  output logic [MOTORS-1:0]            step,
  output logic [MOTORS-1:0]            dir,
  output logic [MOTORS-1:0]            run,
  output logic                         busy,
  output logic [W-1:0]                 cur_task_id,
  output logic                         seg_done,
  output logic [W-1:0]                 seg_count
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  seg_t mem [DEPTH];
  seg_t wr_seg;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0] psc;
  logic flush, push, pop, tick;
  assign flush = abort || sclr;
  assign push  = wr && !full && !flush;
  assign pop   = state == LOAD;
  assign full  = level == (AW+1)'(DEPTH);
  assign busy  = state != IDLE || level != '0;
  assign tick  = state == RUN && permit && psc >= T_scale;
  always_comb begin
    wr_seg = '0;
    wr_seg.task_id = task_id;
    for (int i = 0; i < MOTORS; i++) begin
      wr_seg.n[i] = N[i];
      wr_seg.t[i] = T[i];
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_seg;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level  <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  // prescaler restarts on every LOAD so each segment's first step is aligned to RUN entry
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) psc <= '0;
    else if (flush || pop) psc <= '0;
    else if (permit) psc <= psc >= T_scale ? '0 : psc + 1'b1;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      state       <= IDLE;
      seg_done    <= 1'b0;
      cur_task_id <= '0;
    end else if (flush) begin
      state       <= IDLE;
      seg_done    <= 1'b0;
      cur_task_id <= sclr ? '0 : cur_task_id;
    end else begin
      seg_done <= 1'b0;
      case (state)
        IDLE: state <= level != '0 ? LOAD : IDLE;
        LOAD: begin
          cur_task_id <= mem[rd_ptr].task_id;
          state       <= RUN;
        end
        RUN: if (run == '0) begin
          state    <= SYNC;
          seg_done <= 1'b1;
        end
        SYNC: state <= level != '0 ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < MOTORS; i++) begin : g_axis
    axis_step_gen u_axis (
      .clk    (clk),
      .aclr_n (aclr_n),
      .clr    (flush),
      .ld     (pop),
      .tick   (tick),
      .n      (mem[rd_ptr].n[i]),
      .t      (mem[rd_ptr].t[i]),
      .step   (step[i]),
      .dir    (dir[i]),
      .run    (run[i])
    );
  end
`ifdef MOTOR_QUEUE_STAT_EN
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) seg_count <= '0;
    else if (sclr) seg_count <= '0;
    else if (seg_done) seg_count <= seg_count + 1'b1;
`else
  assign seg_count = '0;
`endif
endmodule

// File: tb/tb_motor_queue_cont.sv
// tb_motor_queue_cont: directed segments with a scoreboard of expected per-segment step
// counts, periods, directions and task ids, checked as steps and seg_done pulses appear.
module tb_motor_queue_cont;
  localparam int M = 2;
  localparam int D = 4;
  logic clk = 1'b0, aclr_n = 1'b0, sclr = 1'b0, abort = 1'b0, permit = 1'b1, wr = 1'b0;
  logic [15:0] T_scale = '0;
  logic [M-1:0][31:0] N = '0, T = '0;
  logic [31:0] task_id = '0;
  logic full, busy, seg_done;
  logic [2:0] level;
  logic [M-1:0] step, dir, run;
  logic [31:0] cur_task_id, seg_count;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] id;
    int cnt [M];
    int p [M];
    bit dir [M];
    bit b2b;
  } exp_t;
  exp_t sb [$];
  exp_t e;
  int cyc = 0, prev_done = -100, ml;
  int seen [M] = '{default: 0};
  int last [M] = '{default: -1};
  int stall [M] = '{default: 0};
  longint t1, t2;
  always #5 clk = ~clk;
  motor_queue_cont #(.MOTORS(M), .DEPTH(D)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .abort(abort), .permit(permit), .T_scale(T_scale),
    .wr(wr), .N(N), .T(T), .task_id(task_id), .full(full), .level(level), .step(step), .dir(dir),
    .run(run), .busy(busy), .cur_task_id(cur_task_id), .seg_done(seg_done), .seg_count(seg_count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // call at posedge+1; leaves the bench at posedge+1 just after the push edge
  task automatic push_seg(input int n0, n1, t0, t1, input logic [31:0] id, input bit b2b, input bit keep);
    exp_t x;
    wr = 1'b1;
    N[0] = n0;
    N[1] = n1;
    T[0] = t0;
    T[1] = t1;
    task_id = id;
    x.id = id;
    x.b2b = b2b;
    x.cnt[0] = n0 < 0 ? -n0 : n0;
    x.cnt[1] = n1 < 0 ? -n1 : n1;
    x.p[0] = (t0 < 1 ? 1 : t0) * (int'(T_scale) + 1);
    x.p[1] = (t1 < 1 ? 1 : t1) * (int'(T_scale) + 1);
    x.dir[0] = n0 < 0;
    x.dir[1] = n1 < 0;
    if (keep) sb.push_back(x);
    cyc_wait(1);
    wr = 1'b0;
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, busy, 0);
    cyc_wait(1);
  endtask
  task automatic wait_step0(input string tag, input int budget);
    int k = 0;
    while (step[0] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_seen"}, step[0], 1);
  endtask
  // monitor: steps and seg_done are scored against the head of the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b0)
      for (int i = 0; i < M; i++) begin
        seen[i] = 0;
        last[i] = -1;
        stall[i] = 0;
      end
    for (int i = 0; i < M; i++)
      if (step[i] === 1'b1) begin
        chk($sformatf("step%0d_expected", i), sb.size() != 0, 1);
        if (sb.size() != 0) begin
          if (last[i] >= 0)
            chk($sformatf("gap%0d_id%0d", i, sb[0].id), cyc - last[i], sb[0].p[i] + stall[i]);
          else if (sb[0].b2b)
            chk($sformatf("first%0d_id%0d", i, sb[0].id), cyc - prev_done, 2 + sb[0].p[i]);
          chk($sformatf("dir%0d_id%0d", i, sb[0].id), dir[i], sb[0].dir[i]);
        end
        seen[i]++;
        last[i] = cyc;
        stall[i] = 0;
      end
    for (int i = 0; i < M; i++)
      if (permit === 1'b0 && last[i] >= 0) stall[i]++;
    if (seg_done === 1'b1) begin
      chk("seg_done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("task_id_%0d", e.id), cur_task_id, e.id);
        ml = -1;
        for (int i = 0; i < M; i++) begin
          chk($sformatf("count%0d_id%0d", i, e.id), seen[i], e.cnt[i]);
          if (last[i] > ml) ml = last[i];
        end
        if (ml >= 0) chk($sformatf("sync_gap_id%0d", e.id), cyc - ml, 1);
      end
      prev_done = cyc;
      for (int i = 0; i < M; i++) begin
        seen[i] = 0;
        last[i] = -1;
        stall[i] = 0;
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_flags", {full, busy, seg_done}, 0);
    chk("rst_axes", {step, dir, run}, 0);
    chk("rst_task", cur_task_id, 0);
    chk("rst_count", seg_count, 0);
    aclr_n = 1'b1;
    cyc_wait(2);
    // single two-axis segment, opposite directions
    push_seg(3, -2, 4, 5, 1, 0, 1);
    wait_idle("seg1", 200);
    chk("seg1_dir", dir, 2'b10);
    chk("seg1_run", run, 0);
    chk("seg1_sb_empty", sb.size(), 0);
    // three back-to-back segments
    push_seg(2, 1, 3, 2, 10, 0, 1);
    push_seg(-1, 3, 2, 1, 11, 1, 1);
    push_seg(1, -2, 1, 4, 12, 1, 1);
    wait_idle("b2b", 300);
    chk("b2b_task", cur_task_id, 12);
    chk("b2b_sb_empty", sb.size(), 0);
    // fill while the running segment is frozen
    permit = 1'b0;
    push_seg(1, 0, 1, 1, 20, 0, 1);
    cyc_wait(4);
    chk("stall_level0", level, 0);
    push_seg(1, 1, 2, 3, 21, 1, 1);
    push_seg(1, 1, 2, 3, 22, 1, 1);
    push_seg(1, 1, 2, 3, 23, 1, 1);
    chk("fill3_full", full, 0);
    chk("fill3_level", level, 3);
    push_seg(1, 1, 2, 3, 24, 1, 1);
    chk("fill4_full", full, 1);
    chk("fill4_level", level, 4);
    push_seg(1, 1, 2, 3, 25, 1, 0);
    chk("fill5_full", full, 1);
    chk("fill5_level", level, 4);
    chk("fill_busy", busy, 1);
    permit = 1'b1;
    wait_idle("drain", 400);
    chk("drain_sb_empty", sb.size(), 0);
    // abort mid-run with two queued, push in the abort cycle dropped
    push_seg(20, 20, 3, 3, 30, 0, 1);
    push_seg(1, 1, 1, 1, 31, 1, 1);
    push_seg(1, 1, 1, 1, 32, 1, 1);
    cyc_wait(4);
    chk("pre_abort_level", level, 2);
    chk("pre_abort_run", run, 2'b11);
    abort = 1'b1;
    wr = 1'b1;
    task_id = 99;
    cyc_wait(1);
    abort = 1'b0;
    wr = 1'b0;
    sb.delete();
    chk("abort_step", step, 0);
    chk("abort_run", run, 0);
    chk("abort_level", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_seg_done", seg_done, 0);
    chk("abort_task_held", cur_task_id, 30);
    cyc_wait(20);
    chk("post_abort_level", level, 0);
    chk("post_abort_busy", busy, 0);
    // zero-step segment still completes
    push_seg(0, 0, 5, 5, 40, 0, 1);
    wait_idle("zero", 100);
    chk("zero_task", cur_task_id, 40);
    chk("zero_sb_empty", sb.size(), 0);
    // prescaled period with a 20-clk permit pause
    T_scale = 16'd3;
    push_seg(3, 0, 2, 1, 50, 0, 1);
    wait_step0("pause_step1", 200);
    t1 = $time;
    cyc_wait(2);
    permit = 1'b0;
    cyc_wait(20);
    permit = 1'b1;
    wait_step0("pause_step2", 200);
    t2 = $time;
    chk("pause_gap", (t2 - t1) / 10, 28);
    wait_idle("pause", 200);
    chk("pause_sb_empty", sb.size(), 0);
    chk("final_task", cur_task_id, 50);
`ifdef MOTOR_QUEUE_STAT_EN
    chk("seg_count", seg_count, 11);
`else
    chk("seg_count", seg_count, 0);
`endif
    sclr = 1'b1;
    cyc_wait(1);
    sclr = 1'b0;
    chk("sclr_task", cur_task_id, 0);
    chk("sclr_count", seg_count, 0);
    chk("sclr_level", level, 0);
    chk("sclr_busy", busy, 0);
    cyc_wait(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/motor_queue_cont.md
MOTOR_QUEUE_CONT -- requirements
Module: motor_queue_cont

Interface
REQ-001 SHALL have parameter MOTORS, default 8: number of axes.
REQ-002 SHALL have parameter DEPTH, default 16: segment queue entries, power of 2, at least 2.
REQ-003 SHALL have ports clk (in, 1, sole clock) and aclr_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports sclr (in, 1, sync clear) and abort (in, 1, stop motion and flush the queue).
REQ-005 SHALL have port permit (in, 1): 0 freezes step timing without losing state.
REQ-006 SHALL have port T_scale (in, 16): prescale; clk_ena fires every T_scale+1 clk.
REQ-007 SHALL have push ports wr (in, 1), N (in, MOTORS x 32, signed steps), T (in, MOTORS x 32, period in clk_ena ticks), task_id (in, 32).
REQ-008 SHALL have status ports full (out, 1) and level (out, clog2(DEPTH)+1, occupied entries).
REQ-009 SHALL have motion ports step (out, MOTORS), dir (out, MOTORS) and run (out, MOTORS, axis has steps left).
REQ-010 SHALL have ports busy (out, 1), cur_task_id (out, 32) and seg_done (out, 1, one-clk pulse).
REQ-011 SHALL have port seg_count (out, 32).

Function
REQ-012 SHALL push one entry on wr && !full; wr while full is dropped; full reflects pre-pop level, so pop does not free space in the same cycle.
REQ-013 SHALL run FSM states IDLE, LOAD, RUN, SYNC; IDLE->LOAD when queue non-empty.
REQ-014 In LOAD (1 clk) SHALL pop the head and latch per axis: cnt=|N|, dir=N<0, per=max(T,1); cur_task_id<=task_id; state goes to RUN.
REQ-015 In RUN SHALL, on each clk_ena && permit, increment each active axis phase counter; at phase==per-1 it resets phase, pulses step high 1 clk and decrements cnt.
REQ-016 SHALL hold run[i]=1 while cnt[i]!=0; an axis with N=0 is never run.
REQ-017 SHALL go RUN->SYNC when all run==0; in SYNC seg_done=1 for 1 clk, then LOAD if non-empty, else IDLE.
REQ-018 Back-to-back segments: SYNC->LOAD->RUN SHALL leave exactly 2 clk with no step between segments.
REQ-019 SHALL restart the prescaler counter on every LOAD so the first step of a segment comes per*(T_scale+1) clk after RUN entry (permit=1).
REQ-020 SHALL hold dir stable from LOAD until the next LOAD; dir SHALL NOT change while step=1.
REQ-021 SHALL keep busy=1 whenever state!=IDLE or level!=0.
REQ-022 On abort (any state) SHALL next clk force step=0, run=0, cnt=0, level=0, state=IDLE; cur_task_id held; seg_done not pulsed.
REQ-023 abort with wr in the same cycle SHALL drop the push.
REQ-024 sclr SHALL act as abort and also clear cur_task_id and seg_count.
REQ-025 permit=0 SHALL freeze phase, cnt and prescaler; FSM states and queue pushes unaffected.
REQ-026 Queue pointers SHALL wrap modulo DEPTH; level SHALL reach DEPTH exactly when full.

Reset
REQ-027 aclr_n=0 SHALL asynchronously set state=IDLE, level=0, step=0, dir=0, run=0, busy=0, seg_done=0, full=0, cur_task_id=0, seg_count=0, prescaler=0.

Configuration
REQ-028 With MOTOR_QUEUE_STAT_EN defined, seg_count SHALL increment (wrapping) at each seg_done.
REQ-029 Without MOTOR_QUEUE_STAT_EN, seg_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-030 Package motor_queue_pkg SHALL hold the FSM state enum, the segment entry struct (N, T arrays, task_id) and the 32-bit width constant.
REQ-031 Per-axis step timing (phase, cnt, dir, run, step) SHALL live in sub-module axis_step_gen, instantiated MOTORS times.

Verification
REQ-032 MOTORS=2, T_scale=0: push N={3,-2}, T={4,5} -> step0 3 pulses 4 clk apart, dir1=1 with 2 pulses 5 clk apart, one seg_done.
REQ-033 Push 3 segments with IDs 10, 11, 12 -> cur_task_id 10->11->12, 3 seg_done pulses, 2-clk step gap each boundary, busy drops after the last.
REQ-034 DEPTH=4: push 5 while stalled with permit=0 -> full after the 4th, 5th dropped, level=4.
REQ-035 Abort mid-RUN with 2 queued -> next clk step=0, level=0, IDLE, no seg_done.
REQ-036 Push N={0,0} -> LOAD, RUN, SYNC, seg_done with no step pulses.
REQ-037 T_scale=3, T=2, permit toggled low 20 clk mid-segment -> step period 8 clk, stretched by exactly 20 clk across the pause.
